// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command handlers (states, reply status codes).
// Pure declarations: no latency and no backpressure.
package cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        SEND0,
        WAIT0,
        SEND1,
        WAIT1,
        DONE
    } state_t;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_MISMATCH = 8'h01;
    localparam logic [7:0] ST_TIMEOUT  = 8'h02;
    localparam logic [7:0] ERR_SAT     = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/check_cnt_seq_checker.sv
// Counting-sequence checker: expected value, 9-bit remaining count, saturating error count.
// Updates one cycle after load/step; no backpressure (step is taken whenever asserted).
module seq_checker
    import cmd_pkg::*;
#(
    parameter logic [7:0] START_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] len,
    input  logic       step,
    input  logic [7:0] data,
    output logic [7:0] err_cnt,
    output logic [7:0] err_cnt_next,
    output logic       last
);

    logic [7:0] expected;
    logic [8:0] remaining;

    // Error count as it will be after stepping with the current data byte.
    assign err_cnt_next = (data != expected) ? sat_inc(err_cnt) : err_cnt;
    assign last         = (remaining == 9'd1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            expected  <= START_VALUE;
            remaining <= 9'd0;
            err_cnt   <= 8'd0;
        end else begin
            if (load) begin
                remaining <= {1'b0, len} + 9'd1;
            end
            if (step) begin
                err_cnt   <= err_cnt_next;
                expected  <= expected + 8'd1;
                remaining <= remaining - 9'd1;
            end
        end
    end

endmodule

// File: rtl/check_cnt.sv
// Receive-side counting test: checks N+1 bytes against a counter, replies status then error count.
// Reply starts the cycle after the last byte; waits on tx_active/tx_done; option CHK_TIMEOUT_EN adds an idle timeout.
module check_cnt
    import cmd_pkg::*;
#(
    parameter logic [7:0]  START_VALUE    = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    output logic       done,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start
);

    state_t     state, state_nxt;
    logic       done_nxt, tx_start_nxt;
    logic [7:0] tx_data_nxt;
    logic [7:0] status, status_nxt;
    logic       rx_ready_q;
    logic       rx_rise;
    logic       chk_clear, chk_load, chk_step;
    logic [7:0] err_cnt, err_cnt_next;
    logic       chk_last;
    logic       timeout;

    assign rx_rise = rx_ready & ~rx_ready_q;

    seq_checker #(
        .START_VALUE(START_VALUE)
    ) u_seq_checker (
        .clk          (clk),
        .reset        (reset),
        .clear        (chk_clear),
        .load         (chk_load),
        .len          (rx_data),
        .step         (chk_step),
        .data         (rx_data),
        .err_cnt      (err_cnt),
        .err_cnt_next (err_cnt_next),
        .last         (chk_last)
    );

`ifdef CHK_TIMEOUT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || rx_rise || !(state == LEN || state == DATA)) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout = (state == LEN || state == DATA) && (idle_cnt >= TIMEOUT_CYCLES - 1);
`else
    // Without the option the timeout never fires; the parameter is inert.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'd0;
            status     <= ST_OK;
            rx_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            done       <= done_nxt;
            tx_start   <= tx_start_nxt;
            tx_data    <= tx_data_nxt;
            status     <= status_nxt;
            rx_ready_q <= rx_ready;
        end
    end

    always_comb begin
        state_nxt    = state;
        done_nxt     = done;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        status_nxt   = status;
        chk_clear    = 1'b0;
        chk_load     = 1'b0;
        chk_step     = 1'b0;

        case (state)
            IDLE: begin
                chk_clear = 1'b1;
                done_nxt  = 1'b0;
                // Wait for the command byte's rx_ready to drop before listening.
                if (activate && !rx_ready) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (!activate) begin
                    state_nxt = IDLE;
                end else if (rx_rise) begin
                    chk_load  = 1'b1;
                    state_nxt = DATA;
                end else if (timeout) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = SEND0;
                end
            end
            DATA: begin
                if (!activate) begin
                    state_nxt = IDLE;
                end else if (rx_rise) begin
                    chk_step = 1'b1;
                    if (chk_last) begin
                        status_nxt = (err_cnt_next == 8'd0) ? ST_OK : ST_MISMATCH;
                        state_nxt  = SEND0;
                    end
                end else if (timeout) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = SEND0;
                end
            end
            SEND0: begin
                if (!tx_active) begin
                    tx_data_nxt  = status;
                    tx_start_nxt = 1'b1;
                    state_nxt    = WAIT0;
                end
            end
            WAIT0: begin
                if (tx_done) begin
                    state_nxt = SEND1;
                end
            end
            SEND1: begin
                if (!tx_active) begin
                    tx_data_nxt  = err_cnt;
                    tx_start_nxt = 1'b1;
                    state_nxt    = WAIT1;
                end
            end
            WAIT1: begin
                if (tx_done) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt = 1'b1;
                if (!activate && !rx_ready && !tx_active) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_check_cnt.sv
// Bench for check_cnt: directed and random byte streams scored against a counting reference model.
module tb_check_cnt;

    localparam logic [7:0] START = 8'h00;

    logic       clk;
    logic       reset;
    logic       activate;
    logic       done;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_active;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;

    int total = 0;
    int bad   = 0;

    logic [7:0] dq[$];
    logic [7:0] tx_q[$];
    bit         force_busy = 1'b0;

    check_cnt #(
        .START_VALUE    (START),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .activate  (activate),
        .done      (done),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART transmitter model: records each byte and checks start/hold rules.
    initial begin
        logic [7:0] cur;
        int n;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_start) begin
                chk("start_while_busy", {31'd0, tx_active}, 32'd0);
                cur = tx_data;
                tx_q.push_back(cur);
                tx_active = 1'b1;
                n = $urandom_range(2, 6);
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    chk("start_pulse_len", {31'd0, tx_start}, 32'd0);
                    chk("tx_data_hold", {24'd0, tx_data}, {24'd0, cur});
                end
                tx_active = 1'b0;
                tx_done   = 1'b1;
            end else begin
                tx_active = force_busy;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 5000 && !done; i++) @(negedge clk);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Reference: count positions whose byte differs from the counting sequence.
    task automatic model(output logic [7:0] st, output logic [7:0] er);
        int errs;
        errs = 0;
        for (int i = 0; i < dq.size(); i++) begin
            if (dq[i] != 8'((int'(START) + i) % 256)) errs++;
        end
        er = (errs > 255) ? 8'hFF : 8'(errs);
        st = (errs == 0) ? 8'h00 : 8'h01;
    endtask

    task automatic run_cmd(input string tag, input bit busy_hold);
        logic [7:0] est, eer;
        tx_q.delete();
        activate = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'(dq.size() - 1));
        for (int i = 0; i < dq.size(); i++) begin
            if (busy_hold && i == dq.size() - 1) force_busy = 1'b1;
            send_byte(dq[i]);
        end
        if (busy_hold) begin
            repeat (20) @(negedge clk);
            chk({tag, "_held_off"}, tx_q.size(), 32'd0);
            force_busy = 1'b0;
        end
        wait_done();
        model(est, eer);
        chk({tag, "_nbytes"}, tx_q.size(), 32'd2);
        if (tx_q.size() == 2) begin
            chk({tag, "_status"}, {24'd0, tx_q[0]}, {24'd0, est});
            chk({tag, "_errcnt"}, {24'd0, tx_q[1]}, {24'd0, eer});
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_held"}, {31'd0, done}, 32'd1);
        activate = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_done_release"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        activate = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        dq = '{8'h00, 8'h01, 8'h02, 8'h03};
        run_cmd("clean4", 1'b0);

        dq = '{8'h00, 8'h01, 8'h07, 8'h03, 8'h09};
        run_cmd("two_err", 1'b0);

        dq.delete();
        for (int i = 0; i < 256; i++) dq.push_back(8'(i));
        run_cmd("wrap256", 1'b0);

        dq.delete();
        for (int i = 0; i < 256; i++) dq.push_back(8'hAA);
        run_cmd("sat256", 1'b0);

        // Abort mid-stream: no reply, done stays low.
        tx_q.delete();
        activate = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h01);
        activate = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_tx", tx_q.size(), 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);

        dq = '{8'h00, 8'h01, 8'h02};
        run_cmd("after_abort", 1'b0);

        dq = '{8'h00, 8'h01, 8'h05};
        run_cmd("busy_hold", 1'b1);

        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(0, 20);
            dq.delete();
            for (int i = 0; i <= len; i++) begin
                if ($urandom_range(0, 3) == 0) dq.push_back(8'($urandom));
                else dq.push_back(8'((int'(START) + i) % 256));
            end
            run_cmd("rand", 1'b0);
        end

`ifdef CHK_TIMEOUT_EN
        tx_q.delete();
        activate = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h00);
        wait_done();
        chk("tmo_nbytes", tx_q.size(), 32'd2);
        if (tx_q.size() == 2) begin
            chk("tmo_status", {24'd0, tx_q[0]}, 32'h02);
            chk("tmo_errcnt", {24'd0, tx_q[1]}, 32'h00);
        end
        activate = 1'b0;
        repeat (3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/check_cnt.md
Name: check_cnt

Overview:
- UART command handler for the receive direction of the counting test.
- The host sends a length byte N, then N+1 data bytes counting START_VALUE, START_VALUE+1, … (mod 256).
- The block checks every data byte against a local expected counter, then replies with a 2-byte status: code, then error count.
- Sits beside the other command handlers under the top-level command dispatcher and shares its UART rx/tx and activate/done handshake.

Parameters:
- START_VALUE, 8'h00, expected value of the first data byte.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles allowed between received bytes. Used only when CHK_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- activate  in  1  level from dispatcher; high while this command is selected
- done  out  1  high when the reply is fully sent; held until released
- rx_ready  in  1  UART receiver byte-valid level; a byte is taken on each 0->1 transition
- rx_data  in  8  received byte, valid while rx_ready is high
- tx_active  in  1  UART transmitter busy
- tx_done  in  1  one-cycle pulse at the end of each transmitted byte
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done
- tx_start  out  1  one-cycle request to transmit tx_data

Behaviour:
- Reset (synchronous, active-high): state=IDLE, done=0, tx_start=0, tx_data=0, err_cnt=0, expected=START_VALUE, remaining=0, rx_ready_q=0.
- All outputs are registered. rx_rise = rx_ready & ~rx_ready_q.
- IDLE: clear err_cnt and expected. If activate=1 and rx_ready=0, go to LEN. This waits for the rx line to clear after command decode.
- LEN: on rx_rise, remaining(9b) = rx_data+1 (range 1..256), then go to DATA.
- DATA: on rx_rise:
  - If rx_data != expected, err_cnt = err_cnt+1, saturating at 8'hFF.
  - expected = expected+1 (8-bit wrap, 8'hFF -> 8'h00).
  - remaining = remaining-1.
  - When remaining reaches 0, set status = (err_cnt_next==0) ? 8'h00 : 8'h01 and go to SEND0.
- SEND0: when tx_active=0, drive tx_data=status and pulse tx_start for 1 cycle, then go to WAIT0.
- WAIT0: on tx_done, go to SEND1.
- SEND1: when tx_active=0, drive tx_data=err_cnt and pulse tx_start for 1 cycle, then go to WAIT1.
- WAIT1: on tx_done, go to DONE.
- DONE: done=1. When activate=0, rx_ready=0 and tx_active=0, set done=0 and go to IDLE.
- Abort: activate=0 while in LEN or DATA sends the block to IDLE next cycle with no reply and done stays 0. activate=0 during SEND/WAIT states does not abort; the reply completes.
- rx_rise while in SEND*/WAIT*/DONE is ignored.
- tx_start is never high on two consecutive cycles. tx_start is never asserted while tx_active=1.
- Synchronous reset mid-operation returns to IDLE next cycle and drops tx_start immediately. A UART byte already in flight is not cancelled.
- Latency: SEND0 is entered on the cycle after the final data byte's rx_rise. tx_start follows in the next cycle in which tx_active=0.

Optional Feature:
- Macro: CHK_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter runs in LEN and DATA and resets on every rx_rise.
  - When it reaches TIMEOUT_CYCLES, set status=8'h02 and go to SEND0.
  - The second reply byte is the current err_cnt.
- Undefined: no counter; LEN and DATA wait indefinitely.
- Status 8'h02 is never produced without the macro.

Decomposition:
- Package cmd_pkg holds:
  - state enum: IDLE, LEN, DATA, SEND0, WAIT0, SEND1, WAIT1, DONE;
  - status codes: ST_OK=8'h00, ST_MISMATCH=8'h01, ST_TIMEOUT=8'h02;
  - ERR_SAT=8'hFF.
- Natural sub-module: seq_checker. It holds expected, remaining and err_cnt, with load/step/clear inputs and a last output. It is reusable by a future loopback test.

Test Plan:
- activate=1, send 8'h03 then 00,01,02,03 -> tx bytes 8'h00, 8'h00; done=1.
- Send 8'h04 then 00,01,07,03,09 -> replies 8'h01, 8'h02 (two mismatches).
- Send 8'hFF then 256 bytes 00..FF -> replies 00,00. Expected wraps and the 9-bit remaining handles 256 bytes.
- Send length 8'hFF then 256 bytes all 8'hAA -> err_cnt saturates; replies 8'h01, 8'hFF.
- Send 8'h05 then 00,01, then drop activate -> no tx_start, done=0, back in IDLE. A new activate then runs a clean check.
- With CHK_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 8'h02, 00, then silence -> after 100 idle cycles replies 8'h02, 8'h00. Also hold tx_active=1 across SEND0 and check tx_start is held off.
